ook_demod: RTL

//  OOK receiver: the far end of the DDS OOK transmitter. Takes 8-bit offset-binary ADC samples
//  (mid-scale 128 = no carrier), detects the carrier envelope, and slices UART-style frames into bytes.

---
 rtl/ook_pkg.sv | 20 ++
 rtl/ook_env_det.sv | 80 ++++++++
 rtl/ook_demod.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ook_pkg.sv
// Shared definitions for the OOK receiver: bit-FSM states, ADC mid-scale and frame length.
package ook_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0]  ADC_MID    = 8'd128;
  localparam int unsigned FRAME_BITS = 8;
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

  // |sample - mid-scale| for offset-binary samples; range 0..128
  function automatic logic [7:0] adc_mag(input logic [7:0] s);
    return (s >= ADC_MID) ? (s - ADC_MID) : (ADC_MID - s);
  endfunction

endpackage

// File: rtl/ook_env_det.sv
// Carrier envelope detector: magnitude, integrate-and-dump, threshold decision.
// Optional hysteresis when OOK_DEMOD_HYST_EN is defined.
module ook_env_det
  import ook_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc,
  input  logic [7:0] thresh_hi,
  input  logic [7:0] thresh_lo,
  output logic       det
);

  localparam int unsigned ACC_W = 8 + WIN_LOG2;

  logic [7:0]          mag_c;
  logic [ACC_W-1:0]    sum_c;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]          env_q, env_d;
  logic                env_vld_q, env_vld_d;
  logic                det_q, det_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      win_cnt_q <= '0;
      env_q     <= '0;
      env_vld_q <= 1'b0;
      det_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      env_q     <= env_d;
      env_vld_q <= env_vld_d;
      det_q     <= det_d;
    end
  end

  always_comb begin
    mag_c     = adc_mag(adc);
    sum_c     = acc_q + ACC_W'(mag_c);
    acc_d     = sum_c;
    win_cnt_d = win_cnt_q + WIN_LOG2'(1);
    env_d     = env_q;
    env_vld_d = 1'b0;
    det_d     = det_q;

    if (&win_cnt_q) begin
      acc_d     = '0;
      env_d     = 8'(sum_c >> WIN_LOG2);
      env_vld_d = 1'b1;
    end

    // Decision is taken the cycle after a fresh envelope value lands
    if (env_vld_q) begin
`ifdef OOK_DEMOD_HYST_EN
      if (thresh_lo > thresh_hi) begin
        det_d = (env_q >= thresh_hi);
      end else if (env_q >= thresh_hi) begin
        det_d = 1'b1;
      end else if (env_q < thresh_lo) begin
        det_d = 1'b0;
      end
`else
      det_d = (env_q >= thresh_hi);
`endif
    end
  end

`ifndef OOK_DEMOD_HYST_EN
  logic unused_thresh_lo;
  assign unused_thresh_lo = ^thresh_lo;
`endif

  assign det = det_q;

endmodule

// File: rtl/ook_demod.sv
// OOK receiver top: envelope detector plus UART-style bit slicer (start, 8 data LSB first, stop).
// Build option: OOK_DEMOD_HYST_EN enables hysteresis in the carrier decision.
module ook_demod
  import ook_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned BIT_CYC  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc,
  input  logic [7:0] thresh_hi,
  input  logic [7:0] thresh_lo,
  output logic       carrier,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int unsigned    CNT_W    = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  logic             det;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sr_q, sr_d;
  logic             det_prev_q, det_prev_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;

  ook_env_det #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_env_det (
    .clk       (clk),
    .rst       (rst),
    .adc       (adc),
    .thresh_hi (thresh_hi),
    .thresh_lo (thresh_lo),
    .det       (det)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      sr_q         <= '0;
      det_prev_q   <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sr_q         <= sr_d;
      det_prev_q   <= det_prev_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Bit-timing FSM; a held-on carrier cannot re-trigger because IDLE needs a rising edge
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    sr_d         = sr_q;
    det_prev_d   = det;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (det && !det_prev_q) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (det) begin
          state_d = DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sr_d  = {det, sr_q[7:1]};
          cnt_d = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (!det) begin
            data_out_d   = sr_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign carrier    = det;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

endmodule
